nested_isqrt_pipe_fifo: RTL and testbench

NESTED_ISQRT_PIPE_FIFO -- requirements
Module: nested_isqrt_pipe_fifo

---
 rtl/nested_isqrt_pkg.sv | 46 ++++
 rtl/flip_flop_fifo_with_counter.sv | 78 +++++++
 rtl/isqrt.sv | 109 ++++++++++
 rtl/nested_isqrt_stage.sv | 96 +++++++++
 rtl/nested_isqrt_pipe_fifo.sv | 67 ++++++
 tb/tb_nested_isqrt_pipe_fifo.sv | 309 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/nested_isqrt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nested_isqrt_pkg
//  Description : Shared sizing helpers and the stage adder for the nested
//                integer square-root pipeline.
//                  fifo_depth    - argument buffer depth of stage k
//                  total_latency - arg_vld to res_vld latency in cycles
//                  stage_add     - WIDTH-bit adder, wrapping or saturating
//  Revision    : 1.0 - initial release
// ============================================================================
package nested_isqrt_pkg;

   localparam int MAX_WIDTH = 64;

   // Stage k waits k*SQRT_STAGES + (k-1) cycles for its y operand, so this
   // depth always leaves at least one free slot.
   function automatic int fifo_depth(input int k, input int sqrt_stages);
      return k * (sqrt_stages + 1);
   endfunction

   function automatic int total_latency(input int n_terms, input int sqrt_stages);
      return n_terms * sqrt_stages + (n_terms - 1);
   endfunction

   // Adds two width-bit operands carried in MAX_WIDTH containers. On carry-out
   // the result either wraps modulo 2^width or clamps to all-ones.
   function automatic logic [MAX_WIDTH-1:0] stage_add(
      input logic [MAX_WIDTH-1:0] a,
      input logic [MAX_WIDTH-1:0] b,
      input int                   width,
      input logic                 sat
   );
      logic [MAX_WIDTH:0]   sum;
      logic [MAX_WIDTH-1:0] mask;
      logic                 carry;
      mask  = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
      sum   = {1'b0, a & mask} + {1'b0, b & mask};
      carry = ((sum >> width) != '0);
      if (sat && carry) begin
         return mask;
      end
      return sum[MAX_WIDTH-1:0] & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/flip_flop_fifo_with_counter.sv
`default_nettype none
// ============================================================================
//  Module      : flip_flop_fifo_with_counter
//  Description : Register-based FIFO with occupancy counter and
//                first-word-fall-through read. DEPTH need not be a power of
//                two. A push while full is accepted only alongside a pop.
//  Ports       : clk, rst (async, active-high)
//                push, push_data     - write side
//                pop,  pop_data      - read side (pop_data valid when !empty)
//                empty, full, count  - status
//  Revision    : 1.0 - initial release
// ============================================================================
module flip_flop_fifo_with_counter #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 17
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty     = (r_count == '0);
   assign full      = (r_count == CW'(DEPTH));
   assign count     = r_count;
   assign pop_data  = r_mem[r_rd_ptr];
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule
`default_nettype wire

// File: rtl/isqrt.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt
//  Description : Pipelined floor square root, digit-by-digit (two radicand
//                bits per step). The WIDTH/2 steps are spread over STAGES
//                register stages; latency is exactly STAGES cycles.
//  Ports       : clk, rst (async, active-high)
//                x_vld, x[WIDTH-1:0]      - radicand in
//                y_vld, y[WIDTH/2-1:0]    - floor(sqrt(x)) out
//  Revision    : 1.0 - initial release
// ============================================================================
module isqrt #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               x_vld,
   input  logic [WIDTH-1:0]   x,
   output logic               y_vld,
   output logic [WIDTH/2-1:0] y
);
   localparam int HALF = WIDTH / 2;
   // Partial remainder never exceeds 2*root, so HALF+3 bits hold it after
   // the two-bit shift-in.
   localparam int RW   = HALF + 3;

   logic [STAGES-1:0] w_stage_vld;
   logic [WIDTH-1:0]  w_stage_x    [STAGES];
   logic [RW-1:0]     w_stage_rem  [STAGES];
   logic [HALF-1:0]   w_stage_root [STAGES];

   for (genvar j = 0; j < STAGES; j++) begin : g_stage
      localparam int LO = j * HALF / STAGES;
      localparam int HI = (j + 1) * HALF / STAGES;

      logic            w_in_vld;
      logic [WIDTH-1:0] w_in_x;
      logic [RW-1:0]   w_in_rem;
      logic [HALF-1:0] w_in_root;
      logic [WIDTH-1:0] w_x;
      logic [RW-1:0]   w_rem;
      logic [RW-1:0]   w_trial;
      logic [HALF-1:0] w_root;
      logic            r_vld;
      logic [WIDTH-1:0] r_x;
      logic [RW-1:0]   r_rem;
      logic [HALF-1:0] r_root;

      if (j == 0) begin : g_head
         assign w_in_vld  = x_vld;
         assign w_in_x    = x;
         assign w_in_rem  = '0;
         assign w_in_root = '0;
      end else begin : g_body
         assign w_in_vld  = w_stage_vld[j-1];
         assign w_in_x    = w_stage_x[j-1];
         assign w_in_rem  = w_stage_rem[j-1];
         assign w_in_root = w_stage_root[j-1];
      end

      // The radicand is kept left-aligned: each step consumes its top two bits.
      always_comb begin
         w_x     = w_in_x;
         w_rem   = w_in_rem;
         w_root  = w_in_root;
         w_trial = '0;
         for (int n = 0; n < HALF; n++) begin
            if (n >= LO && n < HI) begin
               w_rem   = {w_rem[RW-3:0], w_x[WIDTH-1 -: 2]};
               w_x     = {w_x[WIDTH-3:0], 2'b00};
               w_trial = {1'b0, w_root, 2'b01};
               if (w_rem >= w_trial) begin
                  w_rem  = w_rem - w_trial;
                  w_root = {w_root[HALF-2:0], 1'b1};
               end else begin
                  w_root = {w_root[HALF-2:0], 1'b0};
               end
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_vld  <= 1'b0;
            r_x    <= '0;
            r_rem  <= '0;
            r_root <= '0;
         end else begin
            r_vld <= w_in_vld;
            if (w_in_vld) begin
               r_x    <= w_x;
               r_rem  <= w_rem;
               r_root <= w_root;
            end
         end
      end

      assign w_stage_vld[j]  = r_vld;
      assign w_stage_x[j]    = r_x;
      assign w_stage_rem[j]  = r_rem;
      assign w_stage_root[j] = r_root;
   end

   assign y_vld = w_stage_vld[STAGES-1];
   assign y     = w_stage_root[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/nested_isqrt_stage.sv
`default_nettype none
// ============================================================================
//  Module      : nested_isqrt_stage
//  Description : One outer stage (k >= 1) of the nested square root. Buffers
//                its argument until the inner result y_in arrives, registers
//                x = arg + y_in, then takes isqrt(x).
//                Build option NESTED_ISQRT_SAT_EN: saturate the adder to
//                all-ones on carry-out instead of wrapping.
//  Ports       : clk, rst (async, active-high)
//                arg_vld, arg[WIDTH-1:0]    - argument for this stage
//                y_in_vld, y_in[WIDTH/2-1:0] - inner stage result
//                y_vld, y[WIDTH/2-1:0]      - this stage's result
//  Revision    : 1.0 - initial release
// ============================================================================
module nested_isqrt_stage
   import nested_isqrt_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SQRT_STAGES = 16,
   parameter int K           = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arg_vld,
   input  logic [WIDTH-1:0]   arg,
   input  logic               y_in_vld,
   input  logic [WIDTH/2-1:0] y_in,
   output logic               y_vld,
   output logic [WIDTH/2-1:0] y
);
   localparam int DEPTH = fifo_depth(K, SQRT_STAGES);
   localparam int CW    = $clog2(DEPTH + 1);
`ifdef NESTED_ISQRT_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   logic             w_pop;
   logic             w_empty;
   logic             w_full;
   logic [WIDTH-1:0] w_fifo_data;
   logic [CW-1:0]    w_count;
   logic [WIDTH-1:0] w_sum;
   logic             r_x_vld;
   logic [WIDTH-1:0] r_x;

   flip_flop_fifo_with_counter #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (arg_vld),
      .push_data (arg),
      .pop       (w_pop),
      .pop_data  (w_fifo_data),
      .empty     (w_empty),
      .full      (w_full),
      .count     (w_count)
   );

   assign w_pop = y_in_vld && !w_empty;
   assign w_sum = WIDTH'(stage_add(MAX_WIDTH'(w_fifo_data), MAX_WIDTH'(y_in), WIDTH, SAT_EN));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x_vld <= 1'b0;
         r_x     <= '0;
      end else begin
         r_x_vld <= w_pop;
         if (w_pop) begin
            r_x <= w_sum;
         end
      end
   end

   isqrt #(
      .WIDTH  (WIDTH),
      .STAGES (SQRT_STAGES)
   ) u_isqrt (
      .clk   (clk),
      .rst   (rst),
      .x_vld (r_x_vld),
      .x     (r_x),
      .y_vld (y_vld),
      .y     (y)
   );

   // Every inner result must find its matching argument already buffered.
   a_arg_present: assert property (@(posedge clk) disable iff (rst) !(y_in_vld && w_empty));
   a_never_full:  assert property (@(posedge clk) disable iff (rst) !(arg_vld && w_full && !w_pop));
   a_count_range: assert property (@(posedge clk) disable iff (rst) w_count <= CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/nested_isqrt_pipe_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nested_isqrt_pipe_fifo
//  Description : res = isqrt(args[0] + isqrt(args[1] + ... isqrt(args[N-1])))
//                Fully pipelined, one transaction per cycle, fixed latency
//                N_TERMS*SQRT_STAGES + N_TERMS-1. The innermost isqrt takes
//                args[N_TERMS-1] directly; each outer stage buffers its own
//                argument in a FIFO until the inner result arrives.
//                Build option NESTED_ISQRT_SAT_EN: stage adders saturate.
//  Ports       : clk, rst (async, active-high)
//                arg_vld, args[N_TERMS*WIDTH-1:0] - packed terms, args[0] LSBs
//                res_vld, res[WIDTH-1:0]          - result, zero-extended
//  Revision    : 1.0 - initial release
// ============================================================================
module nested_isqrt_pipe_fifo
   import nested_isqrt_pkg::*;
#(
   parameter int N_TERMS     = 3,
   parameter int WIDTH       = 32,
   parameter int SQRT_STAGES = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     arg_vld,
   input  logic [N_TERMS*WIDTH-1:0] args,
   output logic                     res_vld,
   output logic [WIDTH-1:0]         res
);
   localparam int HALF = WIDTH / 2;

   logic [N_TERMS-1:0] w_y_vld;
   logic [HALF-1:0]    w_y [N_TERMS];

   isqrt #(
      .WIDTH  (WIDTH),
      .STAGES (SQRT_STAGES)
   ) u_isqrt_0 (
      .clk   (clk),
      .rst   (rst),
      .x_vld (arg_vld),
      .x     (args[(N_TERMS-1)*WIDTH +: WIDTH]),
      .y_vld (w_y_vld[0]),
      .y     (w_y[0])
   );

   for (genvar k = 1; k < N_TERMS; k++) begin : g_stage
      nested_isqrt_stage #(
         .WIDTH       (WIDTH),
         .SQRT_STAGES (SQRT_STAGES),
         .K           (k)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .arg_vld  (arg_vld),
         .arg      (args[(N_TERMS-1-k)*WIDTH +: WIDTH]),
         .y_in_vld (w_y_vld[k-1]),
         .y_in     (w_y[k-1]),
         .y_vld    (w_y_vld[k]),
         .y        (w_y[k])
      );
   end

   assign res_vld = w_y_vld[N_TERMS-1];
   assign res     = {{(WIDTH-HALF){1'b0}}, w_y[N_TERMS-1]};

endmodule
`default_nettype wire

// File: tb/tb_nested_isqrt_pipe_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nested_isqrt_pipe_fifo
//  Description : Self-checking bench for nested_isqrt_pipe_fifo. A default
//                instance (3 x 32 bit, 16 stages) and a small instance
//                (2 x 16 bit, 8 stages) are driven from directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nested_isqrt_pipe_fifo;
   localparam int N  = 3;
   localparam int W  = 32;
   localparam int S  = 16;
   localparam int L  = 50;
   localparam int N2 = 2;
   localparam int W2 = 16;
   localparam int S2 = 8;
   localparam int L2 = 17;
`ifdef NESTED_ISQRT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            arg_vld = 1'b0;
   logic [N*W-1:0]  args = '0;
   logic            res_vld;
   logic [W-1:0]    res;
   logic            arg_vld2 = 1'b0;
   logic [N2*W2-1:0] args2 = '0;
   logic            res_vld2;
   logic [W2-1:0]   res2;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int           out_cyc[$];
   logic [W-1:0] out_val[$];
   int           exp_cyc[$];
   logic [W-1:0] exp_val[$];
   int            out_cyc2[$];
   logic [W2-1:0] out_val2[$];

   nested_isqrt_pipe_fifo #(.N_TERMS(N), .WIDTH(W), .SQRT_STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .arg_vld(arg_vld), .args(args), .res_vld(res_vld), .res(res));

   nested_isqrt_pipe_fifo #(.N_TERMS(N2), .WIDTH(W2), .SQRT_STAGES(S2)) u_dut2 (
      .clk(clk), .rst(rst), .arg_vld(arg_vld2), .args(args2), .res_vld(res_vld2), .res(res2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (res_vld) begin
         out_cyc.push_back(cyc);
         out_val.push_back(res);
      end
      if (res_vld2) begin
         out_cyc2.push_back(cyc);
         out_val2.push_back(res2);
      end
   end

   // Reference: bitwise greedy floor square root.
   function automatic logic [31:0] isqrt_ref(input logic [63:0] v);
      logic [31:0] r;
      logic [31:0] t;
      r = '0;
      for (int b = 31; b >= 0; b--) begin
         t = r | (32'd1 << b);
         if (64'(t) * 64'(t) <= v) r = t;
      end
      return r;
   endfunction

   function automatic logic [63:0] add_ref(input logic [63:0] a, input logic [63:0] y);
      logic [64:0] s;
      s = {1'b0, a} + {1'b0, y};
      if (s > 65'h0_FFFF_FFFF) return SAT ? 64'hFFFF_FFFF : (s[63:0] & 64'hFFFF_FFFF);
      return s[63:0];
   endfunction

   function automatic logic [W-1:0] nested_ref(input logic [31:0] a0, input logic [31:0] a1,
                                               input logic [31:0] a2);
      logic [31:0] y;
      y = isqrt_ref(64'(a2));
      y = isqrt_ref(add_ref(64'(a1), 64'(y)));
      y = isqrt_ref(add_ref(64'(a0), 64'(y)));
      return y;
   endfunction

   task automatic clear_logs();
      out_cyc.delete(); out_val.delete(); exp_cyc.delete(); exp_val.delete();
      out_cyc2.delete(); out_val2.delete();
   endtask

   task automatic send(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [W-1:0] expv);
      @(negedge clk);
      arg_vld = 1'b1;
      args    = {a2, a1, a0};
      exp_cyc.push_back(cyc + L);
      exp_val.push_back(expv);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         arg_vld  = 1'b0;
         arg_vld2 = 1'b0;
      end
   endtask

   task automatic test_reset();
      arg_vld  = 1'b1;
      args     = {32'd100, 32'd7, 32'd9};
      arg_vld2 = 1'b1;
      args2    = {16'd49, 16'd9};
      repeat (3) @(negedge clk);
      checks++;
      if (res_vld !== 1'b0) begin errors++; $display("FAIL reset_res_vld: got %b expected 0", res_vld); end
      checks++;
      if (res !== '0) begin errors++; $display("FAIL reset_res: got %0d expected 0", res); end
      checks++;
      if (res_vld2 !== 1'b0) begin errors++; $display("FAIL reset_res_vld2: got %b expected 0", res_vld2); end
      checks++;
      if (res2 !== '0) begin errors++; $display("FAIL reset_res2: got %0d expected 0", res2); end
      @(negedge clk);
      rst = 1'b0; arg_vld = 1'b0; arg_vld2 = 1'b0;
      idle(L + 10);
      checks++;
      if (out_val.size() != 0) begin errors++; $display("FAIL reset_discard: got %0d results expected 0", out_val.size()); end
      checks++;
      if (out_val2.size() != 0) begin errors++; $display("FAIL reset_discard2: got %0d results expected 0", out_val2.size()); end
      clear_logs();
   endtask

   task automatic test_basic();
      clear_logs();
      send(32'd0, 32'd0, 32'd16, 32'd1);
      idle(L + 10);
      checks++;
      if (out_val.size() != 1) begin errors++; $display("FAIL basic_count: got %0d results expected 1", out_val.size()); end
      else begin
         checks++;
         if (out_val[0] !== 32'd1) begin errors++; $display("FAIL basic_res: got %0d expected 1", out_val[0]); end
         checks++;
         if (out_cyc[0] !== exp_cyc[0]) begin errors++; $display("FAIL basic_latency: got cycle %0d expected %0d", out_cyc[0], exp_cyc[0]); end
      end
   endtask

   task automatic test_directed();
      clear_logs();
      send(32'd0,          32'd0,   32'd0,          32'd0);
      send(32'd21,         32'd7,   32'd81,         32'd5);
      send(32'd157,        32'd134, 32'd100,        32'd13);
      send(32'hFFFF_FF00,  32'd1,   32'hFFFF_FFFF,  SAT ? 32'd65535 : 32'd0);
      send(32'd0,          32'd0,   32'd16,         32'd1);
      idle(L + 10);
      checks++;
      if (out_val.size() != exp_val.size()) begin errors++; $display("FAIL directed_count: got %0d expected %0d", out_val.size(), exp_val.size()); end
      for (int i = 0; i < exp_val.size() && i < out_val.size(); i++) begin
         checks++;
         if (out_val[i] !== exp_val[i] || out_cyc[i] !== exp_cyc[i]) begin
            errors++;
            $display("FAIL directed_%0d: got res=%0d at cycle %0d, expected res=%0d at cycle %0d",
                     i, out_val[i], out_cyc[i], exp_val[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a0, a1, a2;
      clear_logs();
      for (int i = 0; i < 200; i++) begin
         a0 = $urandom(); a1 = $urandom(); a2 = $urandom();
         if (i % 4 == 1) a1 = a1 & 32'h0000_FFFF;
         if (i % 4 == 2) a0 = a0 & 32'h0000_00FF;
         send(a0, a1, a2, nested_ref(a0, a1, a2));
      end
      idle(L + 10);
      checks++;
      if (out_val.size() != 200) begin errors++; $display("FAIL b2b_count: got %0d expected 200", out_val.size()); end
      for (int i = 0; i < exp_val.size() && i < out_val.size(); i++) begin
         checks++;
         if (out_val[i] !== exp_val[i] || out_cyc[i] !== exp_cyc[i]) begin
            errors++;
            $display("FAIL b2b_%0d: got res=%0d at cycle %0d, expected res=%0d at cycle %0d",
                     i, out_val[i], out_cyc[i], exp_val[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_gaps();
      logic [31:0] a0, a1, a2;
      clear_logs();
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(99) < 30) begin
            a0 = $urandom(); a1 = $urandom_range(100000); a2 = $urandom();
            send(a0, a1, a2, nested_ref(a0, a1, a2));
         end else begin
            idle(1);
         end
      end
      idle(L + 10);
      checks++;
      if (out_val.size() != exp_val.size()) begin errors++; $display("FAIL gaps_count: got %0d expected %0d", out_val.size(), exp_val.size()); end
      for (int i = 0; i < exp_val.size() && i < out_val.size(); i++) begin
         checks++;
         if (out_val[i] !== exp_val[i] || out_cyc[i] !== exp_cyc[i]) begin
            errors++;
            $display("FAIL gaps_%0d: got res=%0d at cycle %0d, expected res=%0d at cycle %0d",
                     i, out_val[i], out_cyc[i], exp_val[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_saturation();
      clear_logs();
      send(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, SAT ? 32'd255 : 32'd15);
      idle(L + 10);
      checks++;
      if (out_val.size() != 1) begin errors++; $display("FAIL sat_count: got %0d expected 1", out_val.size()); end
      else begin
         checks++;
         if (out_val[0] !== exp_val[0] || out_cyc[0] !== exp_cyc[0]) begin
            errors++;
            $display("FAIL sat_res: got res=%0d at cycle %0d, expected res=%0d at cycle %0d",
                     out_val[0], out_cyc[0], exp_val[0], exp_cyc[0]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      clear_logs();
      for (int i = 0; i < 20; i++) begin
         send($urandom(), $urandom(), $urandom(), '0);
      end
      @(negedge clk);
      rst = 1'b1; arg_vld = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (res_vld !== 1'b0 || res !== '0) begin errors++; $display("FAIL midrst_hold: got vld=%b res=%0d expected vld=0 res=0", res_vld, res); end
      clear_logs();
      @(negedge clk);
      rst     = 1'b0;
      arg_vld = 1'b1;
      args    = {32'd49, 32'd2, 32'd6};
      exp_cyc.push_back(cyc + L);
      exp_val.push_back(32'd3);
      idle(L + 10);
      checks++;
      if (out_val.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d results expected 1", out_val.size()); end
      else begin
         checks++;
         if (out_val[0] !== exp_val[0] || out_cyc[0] !== exp_cyc[0]) begin
            errors++;
            $display("FAIL midrst_res: got res=%0d at cycle %0d, expected res=%0d at cycle %0d",
                     out_val[0], out_cyc[0], exp_val[0], exp_cyc[0]);
         end
      end
   endtask

   task automatic test_param_sweep();
      int            e_cyc[3];
      logic [W2-1:0] e_val[3];
      logic [15:0]   t0[3];
      logic [15:0]   t1[3];
      t0[0] = 16'd9;      t1[0] = 16'd49;     e_val[0] = 16'd4;
      t0[1] = 16'hFF01;   t1[1] = 16'hFFFF;   e_val[1] = SAT ? 16'd255 : 16'd0;
      t0[2] = 16'd3;      t1[2] = 16'd1;      e_val[2] = 16'd2;
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         arg_vld2 = 1'b1;
         args2    = {t1[i], t0[i]};
         e_cyc[i] = cyc + L2;
      end
      idle(L2 + 10);
      checks++;
      if (out_val2.size() != 3) begin errors++; $display("FAIL sweep_count: got %0d expected 3", out_val2.size()); end
      for (int i = 0; i < 3 && i < out_val2.size(); i++) begin
         checks++;
         if (out_val2[i] !== e_val[i] || out_cyc2[i] !== e_cyc[i]) begin
            errors++;
            $display("FAIL sweep_%0d: got res=%0d at cycle %0d, expected res=%0d at cycle %0d",
                     i, out_val2[i], out_cyc2[i], e_val[i], e_cyc[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_directed();
      test_back_to_back();
      test_gaps();
      test_saturation();
      test_reset_midstream();
      test_param_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
